sprite_move_ctrl: RTL

SPRITE_MOVE_CTRL -- requirements
Module: sprite_move_ctrl

---
 rtl/vga_pkg.sv | 38 +++
 rtl/btn_debounce.sv | 48 ++++
 rtl/sprite_move_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared display geometry, direction and FSM encodings for the VGA sprite blocks.
package vga_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned VActive = 480;
  localparam int unsigned XWidth  = 10;
  localparam int unsigned YWidth  = 9;

  typedef enum logic [2:0] {
    DirNone,
    DirUp,
    DirDown,
    DirLeft,
    DirRight
  } dir_e;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StApply
  } fsm_e;

  // Fixed priority: down beats up, right beats left, vertical beats horizontal.
  function automatic dir_e pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    if (down) begin
      return DirDown;
    end else if (up) begin
      return DirUp;
    end else if (right) begin
      return DirRight;
    end else if (left) begin
      return DirLeft;
    end
    return DirNone;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level only
// follows the input once it has held a new value for DEBOUNCE consecutive cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only runs while the input disagrees with the accepted level, so any
  // return to the old level clears it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sprite_move_ctrl.sv
// Moves a square sprite one frame at a time from debounced push-buttons, with
// edge saturation, hold-to-accelerate stepping and a registered hit test.
module sprite_move_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH        = HActive,
  parameter int unsigned HEIGHT       = VActive,
  parameter int unsigned SIZE         = 75,
  parameter int unsigned INIT_X       = 240,
  parameter int unsigned INIT_Y       = 200,
  parameter int unsigned DEBOUNCE     = 1000000,
  parameter int unsigned STEP         = 1,
  parameter int unsigned ACCEL_FRAMES = 30,
  parameter int unsigned MAX_STEP     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BTNU,
  input  logic              BTND,
  input  logic              BTNL,
  input  logic              BTNR,
  input  logic              screenEnd,
  input  logic [XWidth-1:0] x,
  input  logic [YWidth-1:0] y,
  output logic [XWidth-1:0] sqX,
  output logic [YWidth-1:0] sqY,
  output logic              inBounds,
  output logic              moving
);

  localparam int unsigned StepW  = $clog2(MAX_STEP + 1);
  localparam int unsigned StepW1 = StepW + 1;
  localparam int unsigned CntW   = $clog2(ACCEL_FRAMES + 1);
  localparam int unsigned PosW   = 13;
  localparam int unsigned XW1    = XWidth + 1;
  localparam int unsigned YW1    = YWidth + 1;

  localparam logic signed [PosW-1:0] XMaxS = PosW'(WIDTH - SIZE);
  localparam logic signed [PosW-1:0] YMaxS = PosW'(HEIGHT - SIZE);

  logic db_u, db_d, db_l, db_r;
  logic [3:0] btn_q;
  logic se_s1_q, se_s2_q, se_s3_q;
  logic frame_tick;

  fsm_e state_q, state_d;
  dir_e dir_q, dir_d;
  dir_e last_dir_q, last_dir_d;

  logic [StepW-1:0]  step_q, step_d, step_base, step_eff;
  logic [StepW1-1:0] step_dbl;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_base, cnt_inc, cnt_next;
  logic [XWidth-1:0] sqx_q, sqx_d, x_sat;
  logic [YWidth-1:0] sqy_q, sqy_d, y_sat;
  logic              in_q, in_d;
  logic              same_dir;

  logic signed [PosW-1:0] x_wide, y_wide, step_s;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_u (.clk(clk), .reset(reset), .btn(BTNU), .level(db_u));
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_d (.clk(clk), .reset(reset), .btn(BTND), .level(db_d));
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_l (.clk(clk), .reset(reset), .btn(BTNL), .level(db_l));
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_r (.clk(clk), .reset(reset), .btn(BTNR), .level(db_r));

  assign frame_tick = se_s2_q & ~se_s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q      <= '0;
      se_s1_q    <= 1'b0;
      se_s2_q    <= 1'b0;
      se_s3_q    <= 1'b0;
      state_q    <= StIdle;
      dir_q      <= DirNone;
      last_dir_q <= DirNone;
      step_q     <= StepW'(STEP);
      cnt_q      <= '0;
      sqx_q      <= XWidth'(INIT_X);
      sqy_q      <= YWidth'(INIT_Y);
      in_q       <= 1'b0;
    end else begin
      // SAMPLE reads this snapshot, so a debounce change landing on the tick
      // cycle is seen one frame later rather than racing the direction latch.
      btn_q      <= {db_u, db_d, db_l, db_r};
      se_s1_q    <= screenEnd;
      se_s2_q    <= se_s1_q;
      se_s3_q    <= se_s2_q;
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      sqx_q      <= sqx_d;
      sqy_q      <= sqy_d;
      in_q       <= in_d;
    end
  end

  // The frame that completes ACCEL_FRAMES in a row already moves at the doubled step.
  always_comb begin
    same_dir  = (dir_q == last_dir_q);
    step_base = same_dir ? step_q : StepW'(STEP);
    cnt_base  = same_dir ? cnt_q : '0;
    cnt_inc   = cnt_base + CntW'(1);
    step_dbl  = {step_base, 1'b0};
    if (cnt_inc >= CntW'(ACCEL_FRAMES)) begin
      cnt_next = '0;
      step_eff = (step_dbl > StepW1'(MAX_STEP)) ? StepW'(MAX_STEP) : step_dbl[StepW-1:0];
    end else begin
      cnt_next = cnt_inc;
      step_eff = step_base;
    end
  end

  always_comb begin
    x_wide = $signed(PosW'(sqx_q));
    y_wide = $signed(PosW'(sqy_q));
    step_s = $signed(PosW'(step_eff));
    unique case (dir_q)
      DirRight: x_wide = x_wide + step_s;
      DirLeft:  x_wide = x_wide - step_s;
      DirDown:  y_wide = y_wide + step_s;
      DirUp:    y_wide = y_wide - step_s;
      default:  ;
    endcase

    if (x_wide[PosW-1]) begin
      x_sat = '0;
    end else if (x_wide > XMaxS) begin
      x_sat = XWidth'(WIDTH - SIZE);
    end else begin
      x_sat = x_wide[XWidth-1:0];
    end

    if (y_wide[PosW-1]) begin
      y_sat = '0;
    end else if (y_wide > YMaxS) begin
      y_sat = YWidth'(HEIGHT - SIZE);
    end else begin
      y_sat = y_wide[YWidth-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    sqx_d      = sqx_q;
    sqy_d      = sqy_q;
    moving     = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_tick) begin
          state_d = StSample;
        end
      end
      StSample: begin
        dir_d   = pick_dir(btn_q[3], btn_q[2], btn_q[1], btn_q[0]);
        state_d = StApply;
      end
      StApply: begin
        state_d = StIdle;
        sqx_d   = x_sat;
        sqy_d   = y_sat;
        moving  = (x_sat != sqx_q) || (y_sat != sqy_q);
        if (dir_q == DirNone) begin
          step_d     = StepW'(STEP);
          cnt_d      = '0;
          last_dir_d = DirNone;
        end else begin
          step_d     = step_eff;
          cnt_d      = cnt_next;
          last_dir_d = dir_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_d = (XW1'(x) >= XW1'(sqx_q)) && (XW1'(x) < XW1'(sqx_q) + XW1'(SIZE)) &&
           (YW1'(y) >= YW1'(sqy_q)) && (YW1'(y) < YW1'(sqy_q) + YW1'(SIZE));
  end

  assign sqX      = sqx_q;
  assign sqY      = sqy_q;
  assign inBounds = in_q;

endmodule
